// File: rtl/core_data_mem_ctrl_if.sv
// Data-memory bus between the load/store controller (master) and the memory (slave).
// Single-request req/gnt/rvalid protocol with byte enables and word addressing.
interface core_data_mem_ctrl_if #(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH     = 32
);
  logic                      mem_req_o;
  logic                      mem_we_o;
  logic [3:0]                mem_be_o;
  logic [MEM_ADDR_WIDTH-3:0] mem_addr_o;
  logic [DATA_WIDTH-1:0]     mem_wdata_o;
  logic                      mem_gnt_i;
  logic                      mem_rvalid_i;
  logic [DATA_WIDTH-1:0]     mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/core_data_mem_ctrl.sv
// Load/store controller: turns one EX-stage access into a req/gnt/rvalid bus
// transaction, stalling the core until done, misalignment error, or timeout.
module core_data_mem_ctrl #(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [1:0]                size_i,
  input  logic [MEM_ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  output logic [DATA_WIDTH-1:0]     rdata_o,
  output logic                      stall_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic                      err_cause_o,
  core_data_mem_ctrl_if.master      mem
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [2:0]            state;
  logic [7:0]            cnt;
  logic [1:0]            addr_lo;
  logic                  misaligned;
  logic [3:0]            be_next;
  logic [DATA_WIDTH-1:0] wdata_next;
  logic [DATA_WIDTH-1:0] rdata_shifted;

  assign misaligned = (size_i == 2'd3) ||
                      ((size_i == 2'd1) && addr_i[0]) ||
                      ((size_i == 2'd2) && (addr_i[1:0] != 2'd0));

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = wdata_i;
    case (size_i)
      2'd0: begin
        be_next    = 4'b0001 << addr_i[1:0];
        wdata_next = {4{wdata_i[7:0]}};
      end
      2'd1: begin
        be_next    = 4'b0011 << addr_i[1:0];
        wdata_next = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign rdata_shifted = mem.mem_rdata_i >> {addr_lo, 3'b000};
  assign stall_o = ((state == S_IDLE) && req_i) || (state == S_REQ) || (state == S_WAIT);

  // Completion beats timeout when both land on the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      cnt             <= 8'd0;
      addr_lo         <= 2'd0;
      rdata_o         <= '0;
      done_o          <= 1'b0;
      err_o           <= 1'b0;
      err_cause_o     <= 1'b0;
      mem.mem_req_o   <= 1'b0;
      mem.mem_we_o    <= 1'b0;
      mem.mem_be_o    <= 4'd0;
      mem.mem_addr_o  <= '0;
      mem.mem_wdata_o <= '0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_i) begin
            if (misaligned) begin
              state       <= S_ERR;
              err_o       <= 1'b1;
              err_cause_o <= 1'b0;
            end else begin
              state           <= S_REQ;
              mem.mem_req_o   <= 1'b1;
              mem.mem_we_o    <= we_i;
              mem.mem_be_o    <= be_next;
              mem.mem_addr_o  <= addr_i[MEM_ADDR_WIDTH-1:2];
              mem.mem_wdata_o <= wdata_next;
              addr_lo         <= addr_i[1:0];
              cnt             <= 8'd0;
            end
          end
        end
        S_REQ: begin
          if (mem.mem_gnt_i && mem.mem_rvalid_i) begin
            state         <= S_DONE;
            done_o        <= 1'b1;
            mem.mem_req_o <= 1'b0;
            if (!mem.mem_we_o) rdata_o <= rdata_shifted;
          end else if (cnt == CNT_LAST) begin
            state         <= S_ERR;
            err_o         <= 1'b1;
            err_cause_o   <= 1'b1;
            mem.mem_req_o <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
            if (mem.mem_gnt_i) begin
              state         <= S_WAIT;
              mem.mem_req_o <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          if (mem.mem_rvalid_i) begin
            state  <= S_DONE;
            done_o <= 1'b1;
            if (!mem.mem_we_o) rdata_o <= rdata_shifted;
          end else if (cnt == CNT_LAST) begin
            state       <= S_ERR;
            err_o       <= 1'b1;
            err_cause_o <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
